// File: rtl/iotdf_pkg.sv
// Shared types and constants for the IoT data-filter sequencer.
package iotdf_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_BYTES  = 16;
  localparam int unsigned ROUND_WORDS = 8;
  localparam int unsigned N_ROUNDS    = 12;
  localparam int unsigned WORD_W      = BYTE_W * WORD_BYTES;
  localparam int unsigned CYC_W       = $clog2(WORD_BYTES);
  localparam int unsigned DAT_W       = $clog2(ROUND_WORDS);
  localparam int unsigned RND_W       = 4;
  localparam int unsigned FN_W        = 3;
  localparam int unsigned FEN_W       = 7;

  // Filter function codes carried on fn_sel
  localparam int unsigned FN_MAX  = 1;
  localparam int unsigned FN_MIN  = 2;
  localparam int unsigned FN_AVG  = 3;
  localparam int unsigned FN_EXT  = 4;
  localparam int unsigned FN_EXC  = 5;
  localparam int unsigned FN_PMAX = 6;
  localparam int unsigned FN_PMIN = 7;

  // Enable groups that share a valid rule
  localparam logic [FEN_W-1:0] FEN_ROUND =
    FEN_W'((1 << (FN_MAX - 1)) | (1 << (FN_MIN - 1)) | (1 << (FN_AVG - 1)));
  localparam logic [FEN_W-1:0] FEN_HIT =
    FEN_W'((1 << (FN_EXT - 1)) | (1 << (FN_EXC - 1)));
  localparam logic [FEN_W-1:0] FEN_PEAK =
    FEN_W'((1 << (FN_PMAX - 1)) | (1 << (FN_PMIN - 1)));

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // fn_sel -> one-hot enable; code 0 yields no enable
  function automatic logic [FEN_W-1:0] fn_onehot(input logic [FN_W-1:0] sel);
    logic [FEN_W-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < FEN_W; i++) begin
      oh[i] = (sel == FN_W'(i + 1));
    end
    return oh;
  endfunction

endpackage

// File: rtl/iotdf_if.sv
// Host/filter-side bundle of the sequencer.
//  master: host side (drives in_en, iot_in, fn_sel, hit, peak_upd)
//  slave : sequencer side (drives data, counters, pulses, enables, status)
interface iotdf_if;
  import iotdf_pkg::*;

  logic                 in_en;
  logic [BYTE_W-1:0]    iot_in;
  logic [FN_W-1:0]      fn_sel;
  logic                 hit;
  logic                 peak_upd;
  logic [WORD_W-1:0]    data;
  logic [CYC_W-1:0]     cnt_cycle;
  logic [DAT_W-1:0]     cnt_data;
  logic                 word_vld;
  logic                 round_done;
  logic [FEN_W-1:0]     f_en;
  logic                 busy;
  logic                 valid;
  logic                 done;
  logic                 err;

  modport master (
    output in_en, iot_in, fn_sel, hit, peak_upd,
    input  data, cnt_cycle, cnt_data, word_vld, round_done, f_en, busy, valid, done, err
  );

  modport slave (
    input  in_en, iot_in, fn_sel, hit, peak_upd,
    output data, cnt_cycle, cnt_data, word_vld, round_done, f_en, busy, valid, done, err
  );

endinterface

// File: rtl/iotdf_shreg.sv
// Byte shift register assembling 128-bit words, MSB-first.
//  clk, rst  : clock, async active-high reset
//  cap       : capture iot_in this cycle
//  iot_in    : serial byte
//  data      : assembled word
//  cnt_cycle : bytes captured in current word (mod WORD_BYTES)
//  word_vld  : registered pulse, data holds a full word
//  last_c    : combinational, this capture completes a word
module iotdf_shreg
  import iotdf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [BYTE_W-1:0] iot_in,
  output logic [WORD_W-1:0] data,
  output logic [CYC_W-1:0]  cnt_cycle,
  output logic              word_vld,
  output logic              last_c
);

  assign last_c = cap & (cnt_cycle == CYC_W'(WORD_BYTES - 1));

  // cnt_cycle wraps naturally since WORD_BYTES is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      cnt_cycle <= '0;
      word_vld  <= 1'b0;
    end else begin
      word_vld <= last_c;
      if (cap) begin
        data      <= {data[WORD_W-BYTE_W-1:0], iot_in};
        cnt_cycle <= cnt_cycle + CYC_W'(1);
      end
    end
  end

endmodule

// File: rtl/iotdf_ctrl.sv
// Sequencer for the IoT data-filter datapath: word assembly, word/round
// counting, filter-enable decode and host busy/valid/done/err.
//  clk, rst : clock, async active-high reset
//  bus      : iotdf_if.slave (host inputs, datapath and status outputs)
module iotdf_ctrl
  import iotdf_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  iotdf_if.slave bus
);

  state_t             state_q, state_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [DAT_W-1:0]   cnt_data_q, cnt_data_d;
  logic [FEN_W-1:0]   f_en_q, f_en_d;
  logic               round_done_q, round_done_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cap;
  logic               last_c;
  logic               word_vld;
  logic [WORD_W-1:0]  data;
  logic [CYC_W-1:0]   cnt_cycle;

  // Bytes are only accepted while not busy
  assign cap = bus.in_en & ((state_q == IDLE) | (state_q == RUN));

  iotdf_shreg u_shreg (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap),
    .iot_in    (bus.iot_in),
    .data      (data),
    .cnt_cycle (cnt_cycle),
    .word_vld  (word_vld),
    .last_c    (last_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rnd_q        <= '0;
      cnt_data_q   <= '0;
      f_en_q       <= '0;
      round_done_q <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      cnt_data_q   <= cnt_data_d;
      f_en_q       <= f_en_d;
      round_done_q <= round_done_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next state; FLUSH is the cycle after round_done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_en) state_d = RUN;
      RUN:     if (round_done_q) state_d = FLUSH;
      FLUSH:   state_d = (rnd_q == RND_W'(N_ROUNDS - 1)) ? DONE : RUN;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-register values; hit and peak_upd are sampled on the edge
  // that raises word_vld / round_done so valid lines up with those pulses
  always_comb begin
    rnd_d        = rnd_q;
    cnt_data_d   = cnt_data_q;
    f_en_d       = f_en_q;
    err_d        = err_q;
    busy_d       = (state_d == FLUSH) | (state_d == DONE);
    done_d       = (state_d == DONE);
    round_done_d = last_c & (cnt_data_q == DAT_W'(ROUND_WORDS - 1));
    valid_d      = ((|(f_en_q & FEN_ROUND)) & round_done_d)
                 | ((|(f_en_q & FEN_HIT))   & last_c & bus.hit)
                 | ((|(f_en_q & FEN_PEAK))  & round_done_d & bus.peak_upd);

    if (word_vld) cnt_data_d = cnt_data_q + DAT_W'(1);
    if ((state_q == IDLE) && bus.in_en) f_en_d = fn_onehot(bus.fn_sel);
    if (state_q == FLUSH) rnd_d = rnd_q + RND_W'(1);
    if (bus.in_en && ((state_q == FLUSH) || (state_q == DONE))) err_d = 1'b1;
  end

  assign bus.data       = data;
  assign bus.cnt_cycle  = cnt_cycle;
  assign bus.word_vld   = word_vld;
  assign bus.cnt_data   = cnt_data_q;
  assign bus.round_done = round_done_q;
  assign bus.f_en       = f_en_q;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
